// File: rtl/kseq_pkg.sv
// Shared types and timing constants for the kernel stream sequencer.
package kseq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SCAN,
        GAP,
        DRAIN,
        CHECK,
        DONE
    } state_t;

    localparam int unsigned BEAT_CYCLES  = 2;
    localparam int unsigned GAP_BEATS    = 2;
    localparam int unsigned FETCH_CYCLES = 2;
    localparam int unsigned CHECK_CYCLES = 2;
    localparam int unsigned TMR_W        = 2;

endpackage

// File: rtl/kseq_addr_gen.sv
// Beat phase toggle plus 0..N*N-1 pixel address counter, shared by the scan and drain sweeps.
// Next-state values are exported so the parent can register outputs aligned to beat boundaries.
module kseq_addr_gen #(
    parameter int unsigned N  = 8,
    parameter int unsigned AW = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    output logic          phase,
    output logic          phase_nx_c,
    output logic [AW-1:0] addr_nx_c,
    output logic          sweep_end_c
);

    localparam logic [AW-1:0] LAST = AW'(N * N - 1);

    logic [AW-1:0] addr;

    always_comb begin
        phase_nx_c = phase;
        addr_nx_c  = addr;
        if (clr) begin
            phase_nx_c = 1'b0;
            addr_nx_c  = '0;
        end else if (en) begin
            phase_nx_c = ~phase;
            if (phase) begin
                addr_nx_c = (addr == LAST) ? '0 : addr + AW'(1);
            end
        end
    end

    assign sweep_end_c = phase && (addr == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= 1'b0;
            addr  <= '0;
        end else begin
            phase <= phase_nx_c;
            addr  <= addr_nx_c;
        end
    end

endmodule

// File: rtl/kernel_stream_sequencer.sv
// Frame-level pass driver for the kernel bank: scan frame in, drain results back, repeat until stable.
// Optional KSEQ_CORNER_COUNT_EN adds corner_count (harris hits in the latest drain sweep).
module kernel_stream_sequencer
    import kseq_pkg::*;
#(
    parameter int unsigned N           = 8,
    parameter int unsigned BIT_SIZE    = 6,
    parameter int unsigned PIXEL_WIDTH = 8,
    parameter int unsigned MAX_PASSES  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   converged,
    output logic [3:0]             pass_count,
    output logic [BIT_SIZE:0]      frame_addr,
    input  logic [PIXEL_WIDTH-1:0] frame_rdata,
    output logic                   frame_we,
    output logic [PIXEL_WIDTH-1:0] frame_wdata,
    output logic                   k_we,
    output logic [BIT_SIZE:0]      k_addr,
    output logic [PIXEL_WIDTH-1:0] k_data,
    input  logic [PIXEL_WIDTH-1:0] k_result,
`ifdef KSEQ_CORNER_COUNT_EN
    output logic [BIT_SIZE+1:0]    corner_count,
`endif
    input  logic                   k_harris
);

    localparam int unsigned AW = BIT_SIZE + 1;
    localparam int unsigned PW = PIXEL_WIDTH;
    localparam logic [AW-1:0] LAST = AW'(N * N - 1);

    state_t            state, state_nx;
    logic [TMR_W-1:0]  tmr, tmr_d;
    logic              chg, chg_d;
    logic              start_ok;
    logic              phase, phase_nx, sweep_end;
    logic [AW-1:0]     addr_nx;

    logic              busy_d, done_d, converged_d, frame_we_d, k_we_d;
    logic [3:0]        pass_count_d;
    logic [AW-1:0]     frame_addr_d, k_addr_d;
    logic [PW-1:0]     frame_wdata_d, k_data_d;

    assign start_ok = (state == IDLE) && start;

    kseq_addr_gen #(.N(N), .AW(AW)) u_addr_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (state_nx != state),
        .en          ((state == SCAN) || (state == DRAIN)),
        .phase       (phase),
        .phase_nx_c  (phase_nx),
        .addr_nx_c   (addr_nx),
        .sweep_end_c (sweep_end)
    );

    // State register with its phase timer and change flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            tmr   <= '0;
            chg   <= 1'b0;
        end else begin
            state <= state_nx;
            tmr   <= tmr_d;
            chg   <= chg_d;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (start) state_nx = FETCH;
            FETCH: if (tmr == TMR_W'(FETCH_CYCLES - 1)) state_nx = SCAN;
            SCAN:  if (sweep_end) state_nx = GAP;
            GAP:   if (tmr == TMR_W'(GAP_BEATS * BEAT_CYCLES - 1)) state_nx = DRAIN;
            DRAIN: if (sweep_end) state_nx = CHECK;
            CHECK: if (tmr == TMR_W'(CHECK_CYCLES - 1)) begin
                       state_nx = (!chg || (pass_count == 4'(MAX_PASSES))) ? DONE : FETCH;
                   end
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Next values for every registered output, derived from the upcoming state
    always_comb begin
        busy_d        = state_nx inside {FETCH, SCAN, GAP, DRAIN, CHECK};
        done_d        = (state_nx == DONE);
        converged_d   = converged;
        pass_count_d  = pass_count;
        k_we_d        = (state_nx == SCAN);
        k_addr_d      = '0;
        k_data_d      = '0;
        frame_addr_d  = '0;
        frame_we_d    = (state_nx == DRAIN) && phase_nx;
        frame_wdata_d = '0;
        tmr_d         = (state_nx != state) ? '0 : tmr + TMR_W'(1);
        chg_d         = chg;

        if (state_nx == SCAN) begin
            k_addr_d     = addr_nx;
            k_data_d     = phase_nx ? k_data : frame_rdata;
            frame_addr_d = (addr_nx == LAST) ? '0 : addr_nx + AW'(1);
        end else if (state_nx == DRAIN) begin
            k_addr_d     = addr_nx;
            frame_addr_d = addr_nx;
        end
        if (frame_we_d) frame_wdata_d = k_result;

        if (start_ok) begin
            converged_d  = 1'b0;
            pass_count_d = '0;
            chg_d        = 1'b0;
        end
        if ((state == CHECK) && (tmr == '0)) pass_count_d = pass_count + 4'd1;
        if ((state == CHECK) && (state_nx == FETCH)) chg_d = 1'b0;
        if ((state == DRAIN) && phase && (k_result != frame_rdata)) chg_d = 1'b1;
        if (state_nx == DONE) converged_d = ~chg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            converged   <= 1'b0;
            pass_count  <= '0;
            frame_addr  <= '0;
            frame_we    <= 1'b0;
            frame_wdata <= '0;
            k_we        <= 1'b0;
            k_addr      <= '0;
            k_data      <= '0;
        end else begin
            busy        <= busy_d;
            done        <= done_d;
            converged   <= converged_d;
            pass_count  <= pass_count_d;
            frame_addr  <= frame_addr_d;
            frame_we    <= frame_we_d;
            frame_wdata <= frame_wdata_d;
            k_we        <= k_we_d;
            k_addr      <= k_addr_d;
            k_data      <= k_data_d;
        end
    end

`ifdef KSEQ_CORNER_COUNT_EN
    localparam int unsigned CW = BIT_SIZE + 2;
    logic [CW-1:0] corner_count_d;

    // Harris hits are sampled once per drain beat, on the write cycle
    always_comb begin
        corner_count_d = corner_count;
        if ((state_nx == DRAIN) && (state != DRAIN)) begin
            corner_count_d = '0;
        end else if ((state == DRAIN) && phase && k_harris) begin
            corner_count_d = corner_count + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) corner_count <= '0;
        else        corner_count <= corner_count_d;
    end
`else
    logic unused_harris;
    assign unused_harris = k_harris;
`endif

endmodule

// File: tb/tb_kernel_stream_sequencer.sv
// Directed bench for kernel_stream_sequencer with a frame RAM model and a behavioural kernel stub.
module tb_kernel_stream_sequencer;

    localparam int unsigned AW       = 7;
    localparam int unsigned PW       = 8;
    localparam int          PASS_CYC = 264;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          busy, done, converged;
    logic [3:0]    pass_count;
    logic [AW-1:0] frame_addr, k_addr;
    logic [PW-1:0] frame_rdata, frame_wdata, k_data, k_result;
    logic          frame_we, k_we, k_harris;
`ifdef KSEQ_CORNER_COUNT_EN
    logic [AW:0]   corner_count;
`endif

    logic [PW-1:0] fmem [0:127];
    logic [PW-1:0] kmem [0:127];
    logic [PW-1:0] kv;
    logic          load_req;
    int            load_mode;
    logic [PW-1:0] load_val;
    int            stub_mode;
    int            errors = 0;
    int            checks = 0;
    logic [38:0]   all_outs;

    assign all_outs = {busy, done, converged, pass_count, frame_addr, frame_we,
                       frame_wdata, k_we, k_addr, k_data};

    kernel_stream_sequencer #(.N(8), .BIT_SIZE(6), .PIXEL_WIDTH(8), .MAX_PASSES(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .converged    (converged),
        .pass_count   (pass_count),
        .frame_addr   (frame_addr),
        .frame_rdata  (frame_rdata),
        .frame_we     (frame_we),
        .frame_wdata  (frame_wdata),
        .k_we         (k_we),
        .k_addr       (k_addr),
        .k_data       (k_data),
        .k_result     (k_result),
`ifdef KSEQ_CORNER_COUNT_EN
        .corner_count (corner_count),
`endif
        .k_harris     (k_harris)
    );

    always #5 clk = ~clk;

    // Frame RAM: synchronous read, one-cycle latency; bench loads whole frames through load_req
    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < 128; i++) fmem[i] <= (load_mode == 0) ? PW'(i) : load_val;
        end else if (frame_we) begin
            fmem[frame_addr] <= frame_wdata;
        end
        frame_rdata <= fmem[frame_addr];
    end

    always @(posedge clk) if (k_we) kmem[k_addr] <= k_data;

    always_comb begin
        kv       = kmem[k_addr];
        k_result = kv;
        case (stub_mode)
            1:       k_result = (kv == '0) ? '0 : kv - 8'd1;
            2:       k_result = ~kv;
            default: k_result = kv;
        endcase
        k_harris = !k_we && ((k_addr == 7'd9) || (k_addr == 7'd18) || (k_addr == 7'd27));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_frame(input int mode, input logic [PW-1:0] v);
        @(negedge clk);
        load_mode = mode;
        load_val  = v;
        load_req  = 1'b1;
        @(negedge clk);
        load_req  = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run(output int cyc);
        pulse_start();
        cyc = 0;
        while (done !== 1'b1 && cyc < 3000) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (all_outs !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0", all_outs);
        end
`ifdef KSEQ_CORNER_COUNT_EN
        checks++;
        if (corner_count !== '0) begin
            errors++;
            $display("FAIL reset_corner: got %0d want 0", corner_count);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();
        checks++;
        if (all_outs !== '0) begin
            errors++;
            $display("FAIL idle_after_reset: got %h want 0", all_outs);
        end
    endtask

    task automatic test_identity();
        int cyc;
        load_frame(0, '0);
        stub_mode = 0;
        run(cyc);
        checks++;
        if (cyc !== PASS_CYC) begin errors++; $display("FAIL ident_done_cycle: got %0d want %0d", cyc, PASS_CYC); end
        checks++;
        if (pass_count !== 4'd1) begin errors++; $display("FAIL ident_pass_count: got %0d want 1", pass_count); end
        checks++;
        if (converged !== 1'b1) begin errors++; $display("FAIL ident_converged: got %b want 1", converged); end
        for (int i = 0; i < 64; i++) begin
            checks++;
            if (fmem[i] !== PW'(i)) begin errors++; $display("FAIL ident_frame[%0d]: got %0d want %0d", i, fmem[i], i); end
        end
    endtask

    task automatic test_waveform();
        int we_pulses;
        int a;
        bit scan, drain, exp_fwe;
        load_frame(0, '0);
        stub_mode = 0;
        we_pulses = 0;
        pulse_start();
        for (int j = 1; j <= PASS_CYC; j++) begin
            tick();
            scan    = (j >= 2) && (j <= 129);
            drain   = (j >= 134) && (j <= 261);
            a       = scan ? (j - 2) / 2 : (drain ? (j - 134) / 2 : 0);
            exp_fwe = drain && (((j - 134) % 2) == 1);
            checks++;
            if (k_we !== scan) begin errors++; $display("FAIL wave_k_we c%0d: got %b want %b", j, k_we, scan); end
            checks++;
            if (k_addr !== AW'(a)) begin errors++; $display("FAIL wave_k_addr c%0d: got %0d want %0d", j, k_addr, a); end
            checks++;
            if (frame_we !== exp_fwe) begin errors++; $display("FAIL wave_frame_we c%0d: got %b want %b", j, frame_we, exp_fwe); end
            checks++;
            if (busy !== (j < PASS_CYC)) begin errors++; $display("FAIL wave_busy c%0d: got %b", j, busy); end
            checks++;
            if (done !== (j == PASS_CYC)) begin errors++; $display("FAIL wave_done c%0d: got %b", j, done); end
            if (scan) begin
                checks++;
                if (k_data !== PW'(a)) begin errors++; $display("FAIL wave_k_data c%0d: got %0d want %0d", j, k_data, a); end
            end
            if (exp_fwe) begin
                we_pulses++;
                checks++;
                if (frame_addr !== AW'(a) || frame_wdata !== PW'(a)) begin
                    errors++;
                    $display("FAIL wave_write c%0d: got addr %0d data %0d want %0d", j, frame_addr, frame_wdata, a);
                end
            end
        end
        checks++;
        if (we_pulses !== 64) begin errors++; $display("FAIL wave_write_count: got %0d want 64", we_pulses); end
    endtask

    task automatic test_decrement();
        int cyc;
        load_frame(1, 8'd3);
        stub_mode = 1;
        run(cyc);
        checks++;
        if (cyc !== 4 * PASS_CYC) begin errors++; $display("FAIL dec_done_cycle: got %0d want %0d", cyc, 4 * PASS_CYC); end
        checks++;
        if (pass_count !== 4'd4) begin errors++; $display("FAIL dec_pass_count: got %0d want 4", pass_count); end
        checks++;
        if (converged !== 1'b1) begin errors++; $display("FAIL dec_converged: got %b want 1", converged); end
        for (int i = 0; i < 64; i++) begin
            checks++;
            if (fmem[i] !== 8'd0) begin errors++; $display("FAIL dec_frame[%0d]: got %0d want 0", i, fmem[i]); end
        end
    endtask

    task automatic test_invert();
        int cyc;
        load_frame(0, '0);
        stub_mode = 2;
        run(cyc);
        checks++;
        if (cyc !== 8 * PASS_CYC) begin errors++; $display("FAIL inv_done_cycle: got %0d want %0d", cyc, 8 * PASS_CYC); end
        checks++;
        if (pass_count !== 4'd8) begin errors++; $display("FAIL inv_pass_count: got %0d want 8", pass_count); end
        checks++;
        if (converged !== 1'b0) begin errors++; $display("FAIL inv_converged: got %b want 0", converged); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL inv_busy_at_done: got %b want 0", busy); end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL inv_done_pulse_width: got %b want 0", done); end
        repeat (3) tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL inv_start_in_done: busy got %b want 0", busy); end
        checks++;
        if (pass_count !== 4'd8 || converged !== 1'b0) begin
            errors++;
            $display("FAIL inv_hold: got pass_count %0d converged %b want 8 0", pass_count, converged);
        end
        for (int i = 0; i < 64; i++) begin
            checks++;
            if (fmem[i] !== PW'(i)) begin errors++; $display("FAIL inv_frame[%0d]: got %0d want %0d", i, fmem[i], i); end
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        int diffs;
        logic [PW-1:0] snap [0:63];
        load_frame(0, '0);
        stub_mode = 2;
        pulse_start();
        repeat (180) tick();
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (all_outs !== '0) begin errors++; $display("FAIL mid_reset_outputs: got %h want 0", all_outs); end
        for (int i = 0; i < 64; i++) snap[i] = fmem[i];
        repeat (3) tick();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) tick();
        diffs = 0;
        for (int i = 0; i < 64; i++) if (fmem[i] !== snap[i]) diffs++;
        checks++;
        if (diffs !== 0) begin errors++; $display("FAIL mid_no_writes: got %0d changed pixels want 0", diffs); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL mid_idle: busy got %b want 0", busy); end
        checks++;
        if (fmem[0] !== 8'hFF || fmem[22] !== 8'd233 || fmem[23] !== 8'd23) begin
            errors++;
            $display("FAIL mid_partial: got %0d %0d %0d want 255 233 23", fmem[0], fmem[22], fmem[23]);
        end
        stub_mode = 0;
        pulse_start();
        cyc = 0;
        while (done !== 1'b1 && cyc < 3000) begin
            start = (cyc == 50);
            tick();
            cyc++;
        end
        start = 1'b0;
        checks++;
        if (cyc !== PASS_CYC) begin errors++; $display("FAIL mid_clean_pass: got %0d want %0d", cyc, PASS_CYC); end
        checks++;
        if (pass_count !== 4'd1 || converged !== 1'b1) begin
            errors++;
            $display("FAIL mid_clean_status: got pass_count %0d converged %b want 1 1", pass_count, converged);
        end
    endtask

`ifdef KSEQ_CORNER_COUNT_EN
    task automatic test_corner();
        int cyc;
        load_frame(1, 8'd1);
        stub_mode = 1;
        pulse_start();
        cyc = 0;
        while (done !== 1'b1 && cyc < 3000) begin
            tick();
            cyc++;
            if ((cyc % PASS_CYC) == 262) begin
                checks++;
                if (corner_count !== 8'd3) begin errors++; $display("FAIL corner_pass c%0d: got %0d want 3", cyc, corner_count); end
            end
        end
        checks++;
        if (cyc !== 2 * PASS_CYC || pass_count !== 4'd2) begin
            errors++;
            $display("FAIL corner_run: got cyc %0d passes %0d want %0d 2", cyc, pass_count, 2 * PASS_CYC);
        end
        checks++;
        if (corner_count !== 8'd3) begin errors++; $display("FAIL corner_final: got %0d want 3", corner_count); end
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        load_req  = 1'b0;
        load_mode = 0;
        load_val  = '0;
        stub_mode = 0;
        test_reset();
        test_identity();
        test_waveform();
        test_decrement();
        test_invert();
        test_reset_mid();
`ifdef KSEQ_CORNER_COUNT_EN
        test_corner();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
